bounded_counter: RTL and testbench
==================================

# bounded_counter

Parametrised successor to the 4-bit saturating counter. It adds programmable upper and lower bounds, a programmable step size, and a selectable saturate or wrap mode at the limits. It also provides registered terminal-count status, and it feeds the ALU datapath loop and event-count logic wherever a counter must stay inside a software-set window.

## Interface
Parameters:
- N, 8, counter and bound width (N ≥ 2)
- STEP_W, 4, width of step input (1 ≤ STEP_W ≤ N)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-low (asserted at 0)
- up  input  1  count up by step
- down  input  1  count down by step
- load  input  1  load out from in
- load_max  input  1  load max_q from in
- load_min  input  1  load min_q from in
- mode  input  1  0 = saturate at bound, 1 = wrap to opposite bound
- step  input  STEP_W  unsigned increment/decrement magnitude
- in  input  N  load data for count and bounds
- out  output  N  current count
- max_q  output  N  current upper bound
- min_q  output  N  current lower bound
- at_max  output  1  out == max_q
- at_min  output  1  out == min_q
- wrapped  output  1  one-cycle pulse: previous update wrapped
- bad_bounds  output  1  min_q > max_q

## Operation
- Reset (rst=0, async): out=0, max_q=all ones, min_q=0, wrapped=0. The derived flags follow from these values: at_min=1, at_max=0, bad_bounds=0.
- Count operation priority: load > (up XOR down) > hold.
  - up && down both high means hold.
  - step==0 means hold.
- load copies in to out unmodified, even outside [min_q,max_q].
- load_max and load_min are independent of the count operation and may coincide with it. The count operation in that cycle uses the bounds registered before the edge.
- If load_max and load_min are both high, both bounds load the same value.
- bad_bounds=1 blocks up/down: out holds and wrapped=0. load still works.
- Up arithmetic (N+1-bit): sum = out + step.
  - If sum ≤ max_q: out ← sum.
  - Otherwise (this includes out already > max_q): mode 0 → out ← max_q; mode 1 → out ← min_q and wrapped pulses.
  - out == max_q in mode 0 holds at max_q with no pulse.
- Down arithmetic (N+1-bit): the down condition is out ≥ min_q + step.
  - If true: out ← out − step.
  - Otherwise: mode 0 → out ← min_q; mode 1 → out ← max_q and wrapped pulses.
- Wrap discards any residue. The count always lands exactly on the opposite bound.
- No N-bit overflow is ever visible, because arithmetic is evaluated at N+1 bits.

## Timing
- Single clock domain. out, max_q, min_q and wrapped are registered and update one cycle after the sampling edge.
- at_max, at_min and bad_bounds are combinational from registers only. They have no input-to-output paths.
- wrapped is high for exactly one cycle per wrap event. Back-to-back wraps keep it high on consecutive cycles.
- Reset assertion mid-operation clears all state immediately. Deassertion takes effect at the next clk edge.

## Configuration
- BOUNDED_COUNTER_WRAP_EN defined: mode input is honoured, and wrap behaviour and the wrapped pulse are as above.
- Not defined: mode is ignored and the counter always saturates. wrapped is tied to 0 and its register is not built. Ports are unchanged.

## Structure
- Package bounded_counter_pkg holds:
  - op encoding OP_HOLD, OP_LOAD, OP_UP, OP_DOWN
  - mode constants MODE_SAT=0, MODE_WRAP=1
- Sub-module bounded_step is combinational. It takes out, bounds, step, op and mode, and returns the next count plus a wrap flag. The top level holds the registers, priority decode and flags.

## Test plan
- Reset: N=4, STEP_W=2, drive rst=0 mid-count at out=7 → out=0, max_q=15, min_q=0, at_min=1 immediately, without waiting for a clock edge.
- Saturate up:
  - Setup: min=2, max=11, out=10, step=3, mode=0, up.
  - Response: out=11, at_max=1, then holds at 11 for 3 further cycles with wrapped=0.
- Wrap down:
  - Setup: min=2, max=11, out=4, step=3, mode=1, down.
  - Response: out=2→wait, 4−3=1<2, so out=11 and wrapped=1 for one cycle, then 8.
- Priority:
  - load=1, up=1, in=6 → out=6.
  - up=down=1 → out holds.
  - step=0 with up → out holds.
- Bound load collision: out=9, max=11, assert load_max with in=5 together with up, step=1 → out=10 (old bound used). The next up gives out=5 in mode 0.
- Bad bounds: load_min=12 with max=11 → bad_bounds=1, up/down hold out. load in=3 still gives out=3.

Source files
------------

// File: rtl/bounded_counter_pkg.sv
// Shared types for bounded_counter: count-operation encoding, mode constants
// and the priority decode used by the top level.
package bounded_counter_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_e;

  localparam logic MODE_SAT  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  // load wins; otherwise exactly one of up/down with a non-zero step and sane bounds.
  function automatic op_e decode_op(input logic load,
                                    input logic up,
                                    input logic down,
                                    input logic blocked,
                                    input logic step_zero);
    op_e op;
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if ((up ^ down) && !blocked && !step_zero) begin
      op = up ? OP_UP : OP_DOWN;
    end
    return op;
  endfunction

endpackage

// File: rtl/bounded_step.sv
// Combinational next-count calculation for bounded_counter: applies one up or
// down step against the window [min_i, max_i], saturating or wrapping at the edges.
module bounded_step
  import bounded_counter_pkg::*;
#(
  parameter int N      = 8,
  parameter int STEP_W = 4
) (
  input  logic [N-1:0]      cnt_i,
  input  logic [N-1:0]      max_i,
  input  logic [N-1:0]      min_i,
  input  logic [STEP_W-1:0] step_i,
  input  op_e               op_i,
  input  logic              mode_i,
  output logic [N-1:0]      next_o,
  output logic              wrap_o
);

  logic [N-1:0] step_n;
  logic [N:0]   up_sum;
  logic [N:0]   down_floor;

  // One extra bit so neither out + step nor min + step can overflow silently.
  assign step_n     = N'(step_i);
  assign up_sum     = {1'b0, cnt_i} + {1'b0, step_n};
  assign down_floor = {1'b0, min_i} + {1'b0, step_n};

  always_comb begin
    next_o = cnt_i;
    wrap_o = 1'b0;
    case (op_i)
      OP_UP: begin
        if (up_sum <= {1'b0, max_i}) begin
          next_o = up_sum[N-1:0];
        end else if (mode_i == MODE_WRAP) begin
          next_o = min_i;
          wrap_o = 1'b1;
        end else begin
          next_o = max_i;
        end
      end
      OP_DOWN: begin
        if ({1'b0, cnt_i} >= down_floor) begin
          next_o = cnt_i - step_n;
        end else if (mode_i == MODE_WRAP) begin
          next_o = max_i;
          wrap_o = 1'b1;
        end else begin
          next_o = min_i;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/bounded_counter.sv
// Window-bounded up/down counter with programmable bounds and step.
// Define BOUNDED_COUNTER_WRAP_EN to honour mode (wrap) and build the wrapped pulse.
module bounded_counter
  import bounded_counter_pkg::*;
#(
  parameter int N      = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up,
  input  logic              down,
  input  logic              load,
  input  logic              load_max,
  input  logic              load_min,
  input  logic              mode,
  input  logic [STEP_W-1:0] step,
  input  logic [N-1:0]      in,
  output logic [N-1:0]      out,
  output logic [N-1:0]      max_q,
  output logic [N-1:0]      min_q,
  output logic              at_max,
  output logic              at_min,
  output logic              wrapped,
  output logic              bad_bounds
);

  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] hi_q, hi_d;
  logic [N-1:0] lo_q, lo_d;
  logic [N-1:0] step_next;
  logic         step_wrap;
  logic         mode_eff;
  op_e          op;

  assign op = decode_op(load, up, down, bad_bounds, step == '0);

  bounded_step #(
    .N      (N),
    .STEP_W (STEP_W)
  ) u_step (
    .cnt_i  (cnt_q),
    .max_i  (hi_q),
    .min_i  (lo_q),
    .step_i (step),
    .op_i   (op),
    .mode_i (mode_eff),
    .next_o (step_next),
    .wrap_o (step_wrap)
  );

  // The count step above sees the pre-edge bounds even when a bound loads this cycle.
  always_comb begin
    cnt_d = (op == OP_LOAD) ? in : step_next;
    hi_d  = load_max ? in : hi_q;
    lo_d  = load_min ? in : lo_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      hi_q  <= '1;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

`ifdef BOUNDED_COUNTER_WRAP_EN
  logic wrapped_q, wrapped_d;

  assign mode_eff  = mode;
  assign wrapped_d = step_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrapped_q <= 1'b0;
    end else begin
      wrapped_q <= wrapped_d;
    end
  end

  assign wrapped = wrapped_q;
`else
  logic unused_wrap_cfg;

  assign mode_eff        = MODE_SAT;
  assign wrapped         = 1'b0;
  assign unused_wrap_cfg = step_wrap | mode;
`endif

  assign out        = cnt_q;
  assign max_q      = hi_q;
  assign min_q      = lo_q;
  assign at_max     = (cnt_q == hi_q);
  assign at_min     = (cnt_q == lo_q);
  assign bad_bounds = (lo_q > hi_q);

endmodule

// File: tb/tb_bounded_counter.sv
// Self-checking bench for bounded_counter (N=4, STEP_W=2): directed scenarios
// plus randomized traffic against an integer-arithmetic reference model.
module tb_bounded_counter;

  localparam int N      = 4;
  localparam int STEP_W = 2;
`ifdef BOUNDED_COUNTER_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              up, down, load, load_max, load_min, mode;
  logic [STEP_W-1:0] step;
  logic [N-1:0]      data_in;
  logic [N-1:0]      out, max_q, min_q;
  logic              at_max, at_min, wrapped, bad_bounds;

  int checks;
  int errors;

  // Reference state kept as plain integers.
  int m_out, m_max, m_min;
  bit m_wr;

  bounded_counter #(
    .N      (N),
    .STEP_W (STEP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up         (up),
    .down       (down),
    .load       (load),
    .load_max   (load_max),
    .load_min   (load_min),
    .mode       (mode),
    .step       (step),
    .in         (data_in),
    .out        (out),
    .max_q      (max_q),
    .min_q      (min_q),
    .at_max     (at_max),
    .at_min     (at_min),
    .wrapped    (wrapped),
    .bad_bounds (bad_bounds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_out = 0;
    m_max = (1 << N) - 1;
    m_min = 0;
    m_wr  = 1'b0;
  endtask

  task automatic model_apply(input bit ld, input bit lmax, input bit lmin,
                             input bit u, input bit d, input bit md,
                             input int st, input int din);
    int nxt;
    bit w;
    bit wrap_mode;
    nxt = m_out;
    w = 1'b0;
    wrap_mode = WRAP_EN && md;
    if (ld) begin
      nxt = din;
    end else if (u != d && st != 0 && !(m_min > m_max)) begin
      if (u) begin
        if (m_out + st <= m_max) nxt = m_out + st;
        else if (wrap_mode) begin nxt = m_min; w = 1'b1; end
        else nxt = m_max;
      end else begin
        if (m_out - st >= m_min) nxt = m_out - st;
        else if (wrap_mode) begin nxt = m_max; w = 1'b1; end
        else nxt = m_min;
      end
    end
    if (lmax) m_max = din;
    if (lmin) m_min = din;
    m_out = nxt;
    m_wr  = w;
  endtask

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic drive_cycle(input bit ld, input bit lmax, input bit lmin,
                             input bit u, input bit d, input bit md,
                             input int st, input int din);
    load     = ld;
    load_max = lmax;
    load_min = lmin;
    up       = u;
    down     = d;
    mode     = md;
    step     = STEP_W'(st);
    data_in  = N'(din);
    @(posedge clk);
    #1;
    model_apply(ld, lmax, lmin, u, d, md, st, din);
  endtask

  task automatic idle_inputs();
    load = 0; load_max = 0; load_min = 0; up = 0; down = 0; mode = 0;
    step = '0; data_in = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (out !== 4'd0 || max_q !== 4'd15 || min_q !== 4'd0) begin
      errors++;
      $display("FAIL reset_regs: out=%0d max=%0d min=%0d required 0/15/0", out, max_q, min_q);
    end
    checks++;
    if (at_min !== 1'b1 || at_max !== 1'b0 || bad_bounds !== 1'b0 || wrapped !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: at_min=%0b at_max=%0b bad=%0b wr=%0b required 1/0/0/0",
               at_min, at_max, bad_bounds, wrapped);
    end
    rst = 1'b1;
    // Count to 7 with a non-default max, then reset asynchronously mid-cycle.
    drive_cycle(0, 1, 0, 0, 0, 0, 0, 12);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 5);
    drive_cycle(0, 0, 0, 1, 0, 0, 2, 0);
    checks++;
    if (out !== 4'd7) begin
      errors++;
      $display("FAIL reset_precount: out=%0d required 7", out);
    end
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out !== 4'd0 || max_q !== 4'd15 || min_q !== 4'd0 || at_min !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: out=%0d max=%0d min=%0d at_min=%0b required 0/15/0/1",
               out, max_q, min_q, at_min);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic setup_window(input int lo, input int hi, input int start);
    drive_cycle(0, 1, 0, 0, 0, 0, 0, hi);
    drive_cycle(0, 0, 1, 0, 0, 0, 0, lo);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, start);
  endtask

  task automatic test_saturate_up();
    setup_window(2, 11, 10);
    drive_cycle(0, 0, 0, 1, 0, 0, 3, 0);
    checks++;
    if (out !== 4'd11 || at_max !== 1'b1 || wrapped !== 1'b0) begin
      errors++;
      $display("FAIL sat_up: out=%0d at_max=%0b wr=%0b required 11/1/0", out, at_max, wrapped);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, 0, 1, 0, 0, 3, 0);
      checks++;
      if (out !== 4'd11 || wrapped !== 1'b0) begin
        errors++;
        $display("FAIL sat_hold: cycle %0d out=%0d wr=%0b required 11/0", i, out, wrapped);
      end
    end
  endtask

  task automatic test_wrap_down();
    logic [N-1:0] exp1, exp2;
    exp1 = WRAP_EN ? 4'd11 : 4'd2;
    exp2 = WRAP_EN ? 4'd8 : 4'd2;
    setup_window(2, 11, 4);
    drive_cycle(0, 0, 0, 0, 1, 1, 3, 0);
    checks++;
    if (out !== exp1 || wrapped !== WRAP_EN) begin
      errors++;
      $display("FAIL wrap_down: out=%0d wr=%0b required %0d/%0b", out, wrapped, exp1, WRAP_EN);
    end
    drive_cycle(0, 0, 0, 0, 1, 1, 3, 0);
    checks++;
    if (out !== exp2 || wrapped !== 1'b0) begin
      errors++;
      $display("FAIL wrap_after: out=%0d wr=%0b required %0d/0", out, wrapped, exp2);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_o;
    exp_o = WRAP_EN ? 4'd2 : 4'd3;
    setup_window(2, 3, 3);
    for (int i = 0; i < 2; i++) begin
      drive_cycle(0, 0, 0, 1, 0, 1, 3, 0);
      checks++;
      if (out !== exp_o || wrapped !== WRAP_EN) begin
        errors++;
        $display("FAIL b2b_wrap: cycle %0d out=%0d wr=%0b required %0d/%0b",
                 i, out, wrapped, exp_o, WRAP_EN);
      end
    end
  endtask

  task automatic test_priority();
    setup_window(0, 15, 2);
    drive_cycle(1, 0, 0, 1, 0, 0, 1, 6);
    checks++;
    if (out !== 4'd6) begin
      errors++;
      $display("FAIL prio_load: out=%0d required 6", out);
    end
    drive_cycle(0, 0, 0, 1, 1, 0, 1, 0);
    checks++;
    if (out !== 4'd6) begin
      errors++;
      $display("FAIL prio_updown: out=%0d required 6", out);
    end
    drive_cycle(0, 0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (out !== 4'd6) begin
      errors++;
      $display("FAIL prio_step0: out=%0d required 6", out);
    end
    drive_cycle(0, 1, 1, 0, 0, 0, 0, 9);
    checks++;
    if (max_q !== 4'd9 || min_q !== 4'd9) begin
      errors++;
      $display("FAIL both_bounds: max=%0d min=%0d required 9/9", max_q, min_q);
    end
  endtask

  task automatic test_bound_collision();
    setup_window(2, 11, 9);
    drive_cycle(0, 1, 0, 1, 0, 0, 1, 5);
    checks++;
    if (out !== 4'd10 || max_q !== 4'd5) begin
      errors++;
      $display("FAIL collide_old: out=%0d max=%0d required 10/5", out, max_q);
    end
    drive_cycle(0, 0, 0, 1, 0, 0, 1, 0);
    checks++;
    if (out !== 4'd5 || at_max !== 1'b1) begin
      errors++;
      $display("FAIL collide_new: out=%0d at_max=%0b required 5/1", out, at_max);
    end
  endtask

  task automatic test_bad_bounds();
    setup_window(2, 11, 7);
    drive_cycle(0, 0, 1, 0, 0, 0, 0, 12);
    checks++;
    if (bad_bounds !== 1'b1) begin
      errors++;
      $display("FAIL bad_flag: bad=%0b required 1", bad_bounds);
    end
    drive_cycle(0, 0, 0, 1, 0, 1, 3, 0);
    drive_cycle(0, 0, 0, 0, 1, 1, 3, 0);
    checks++;
    if (out !== 4'd7 || wrapped !== 1'b0) begin
      errors++;
      $display("FAIL bad_hold: out=%0d wr=%0b required 7/0", out, wrapped);
    end
    drive_cycle(1, 0, 0, 1, 0, 0, 1, 3);
    checks++;
    if (out !== 4'd3) begin
      errors++;
      $display("FAIL bad_load: out=%0d required 3", out);
    end
    drive_cycle(0, 0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (bad_bounds !== 1'b0) begin
      errors++;
      $display("FAIL bad_clear: bad=%0b required 0", bad_bounds);
    end
  endtask

  task automatic test_random();
    bit ld, lmax, lmin, u, d, md;
    int st, din;
    for (int i = 0; i < 400; i++) begin
      ld   = ($urandom_range(0, 15) == 0);
      lmax = ($urandom_range(0, 11) == 0);
      lmin = ($urandom_range(0, 11) == 0);
      u    = $urandom_range(0, 1);
      d    = $urandom_range(0, 1);
      md   = $urandom_range(0, 1);
      st   = $urandom_range(0, (1 << STEP_W) - 1);
      din  = $urandom_range(0, (1 << N) - 1);
      drive_cycle(ld, lmax, lmin, u, d, md, st, din);
      checks++;
      if (out !== N'(m_out) || max_q !== N'(m_max) || min_q !== N'(m_min)) begin
        errors++;
        $display("FAIL rand_regs: cycle %0d out=%0d max=%0d min=%0d required %0d/%0d/%0d",
                 i, out, max_q, min_q, m_out, m_max, m_min);
      end
      checks++;
      if (at_max !== (m_out == m_max) || at_min !== (m_out == m_min) ||
          bad_bounds !== (m_min > m_max) || wrapped !== m_wr) begin
        errors++;
        $display("FAIL rand_flags: cycle %0d at_max=%0b at_min=%0b bad=%0b wr=%0b required %0b/%0b/%0b/%0b",
                 i, at_max, at_min, bad_bounds, wrapped,
                 (m_out == m_max), (m_out == m_min), (m_min > m_max), m_wr);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_saturate_up();
    test_wrap_down();
    test_back_to_back();
    test_priority();
    test_bound_collision();
    test_bad_bounds();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
